alu_reservation_station: RTL

//  Operand-capturing reservation station that feeds the combinational ALU in the EX stage.
//  - Holds up to ENTRY_NUM dispatched ALU micro-ops.
//  - Wakes up source operands from the common data bus (CDB).
//  - Issues at most one ready op per cycle as {op, in1, in2, rrf_tag}.
//  - Sits between dispatch/rename and the ALU; the ALU result returns on the CDB with rrf_tag.

---
 rtl/alu_reservation_station.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_reservation_station.sv
// Operand-capturing reservation station in front of the EX-stage ALU.
// Captures operands at dispatch or from the CDB and issues the lowest-index ready op each cycle.
module alu_reservation_station #(
    parameter int ENTRY_NUM    = 4,
    parameter int DATA_LEN     = 32,
    parameter int ALU_OP_WIDTH = 4,
    parameter int RRF_TAG_W    = 6
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          kill_i,
    input  logic                          dp_valid_i,
    output logic                          dp_ready_o,
    input  logic [ALU_OP_WIDTH-1:0]       dp_op_i,
    input  logic                          dp_src1_rdy_i,
    input  logic [DATA_LEN-1:0]           dp_src1_i,
    input  logic                          dp_src2_rdy_i,
    input  logic [DATA_LEN-1:0]           dp_src2_i,
    input  logic [RRF_TAG_W-1:0]          dp_rrftag_i,
    input  logic                          cdb_valid_i,
    input  logic [RRF_TAG_W-1:0]          cdb_tag_i,
    input  logic [DATA_LEN-1:0]           cdb_data_i,
    output logic                          iss_valid_o,
    input  logic                          iss_ready_i,
    output logic [ALU_OP_WIDTH-1:0]       iss_op_o,
    output logic [DATA_LEN-1:0]           iss_in1_o,
    output logic [DATA_LEN-1:0]           iss_in2_o,
    output logic [RRF_TAG_W-1:0]          iss_rrftag_o,
    output logic [$clog2(ENTRY_NUM):0]    count_o
);
    localparam int IDX_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
    localparam int CNT_W = $clog2(ENTRY_NUM) + 1;

    logic [ENTRY_NUM-1:0]    busy_vec;
    logic [ENTRY_NUM-1:0]    ready_vec;
    logic [ALU_OP_WIDTH-1:0] op_arr   [ENTRY_NUM];
    logic [DATA_LEN-1:0]     val1_arr [ENTRY_NUM];
    logic [DATA_LEN-1:0]     val2_arr [ENTRY_NUM];
    logic [RRF_TAG_W-1:0]    tag_arr  [ENTRY_NUM];

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             dp_fire;
    logic             iss_fire;
    logic             byp1;
    logic             byp2;

    // Readiness comes from registered state only, so the full flag ignores a same-cycle issue.
    assign dp_ready_o  = (count_reg != CNT_W'(ENTRY_NUM));
    assign dp_fire     = dp_valid_i & dp_ready_o;
    assign iss_valid_o = |ready_vec;
    assign iss_fire    = iss_valid_o & iss_ready_i;
    assign count_o     = count_reg;

    // A source whose producer is broadcasting right now is captured as already ready.
    assign byp1 = cdb_valid_i & ~dp_src1_rdy_i & (dp_src1_i[RRF_TAG_W-1:0] == cdb_tag_i);
    assign byp2 = cdb_valid_i & ~dp_src2_rdy_i & (dp_src2_i[RRF_TAG_W-1:0] == cdb_tag_i);

    // Descending scan: the last hit written is the lowest index.
    always_comb begin
        free_idx = '0;
        sel_idx  = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (!busy_vec[i]) begin
                free_idx = IDX_W'(i);
            end
            if (ready_vec[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        iss_op_o     = '0;
        iss_in1_o    = '0;
        iss_in2_o    = '0;
        iss_rrftag_o = '0;
        if (iss_valid_o) begin
            iss_op_o     = op_arr[sel_idx];
            iss_in1_o    = val1_arr[sel_idx];
            iss_in2_o    = val2_arr[sel_idx];
            iss_rrftag_o = tag_arr[sel_idx];
        end
    end

    assign count_next = count_reg + CNT_W'(dp_fire) - CNT_W'(iss_fire);

    always_ff @(posedge clk_i) begin
        if (reset_i || kill_i) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_entry
        logic                    busy_reg;
        logic                    rdy1_reg;
        logic                    rdy2_reg;
        logic [ALU_OP_WIDTH-1:0] op_reg;
        logic [DATA_LEN-1:0]     val1_reg;
        logic [DATA_LEN-1:0]     val2_reg;
        logic [RRF_TAG_W-1:0]    tag_reg;
        logic                    wr_en;
        logic                    iss_clr;
        logic                    wake1;
        logic                    wake2;

        assign wr_en   = dp_fire && (free_idx == IDX_W'(gi));
        assign iss_clr = iss_fire && (sel_idx == IDX_W'(gi));
        assign wake1   = cdb_valid_i & busy_reg & ~rdy1_reg & (val1_reg[RRF_TAG_W-1:0] == cdb_tag_i);
        assign wake2   = cdb_valid_i & busy_reg & ~rdy2_reg & (val2_reg[RRF_TAG_W-1:0] == cdb_tag_i);

        always_ff @(posedge clk_i) begin
            if (reset_i || kill_i) begin
                busy_reg <= 1'b0;
            end else if (wr_en) begin
                busy_reg <= 1'b1;
            end else if (iss_clr) begin
                busy_reg <= 1'b0;
            end
        end

        // Payload needs no reset: busy gates every use of it.
        always_ff @(posedge clk_i) begin
            if (wr_en) begin
                op_reg   <= dp_op_i;
                tag_reg  <= dp_rrftag_i;
                rdy1_reg <= dp_src1_rdy_i | byp1;
                val1_reg <= byp1 ? cdb_data_i : dp_src1_i;
                rdy2_reg <= dp_src2_rdy_i | byp2;
                val2_reg <= byp2 ? cdb_data_i : dp_src2_i;
            end else begin
                if (wake1) begin
                    rdy1_reg <= 1'b1;
                    val1_reg <= cdb_data_i;
                end
                if (wake2) begin
                    rdy2_reg <= 1'b1;
                    val2_reg <= cdb_data_i;
                end
            end
        end

        assign busy_vec[gi]  = busy_reg;
        assign ready_vec[gi] = busy_reg & rdy1_reg & rdy2_reg;
        assign op_arr[gi]    = op_reg;
        assign val1_arr[gi]  = val1_reg;
        assign val2_arr[gi]  = val2_reg;
        assign tag_arr[gi]   = tag_reg;
    end

endmodule
